// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared definitions for the UART transmit arbiter.
//   BYTE_W       - width of one requester byte lane
//   arb_state_t  - controller states (ARB, ISSUE, START, WAIT_BUSY, WAIT_DONE)
//   rr_next()    - modulo-n increment used to advance the round-robin pointer
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ARB       = 3'd0,
        ISSUE     = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } arb_state_t;

    // Wraps n-1 back to 0 so non-power-of-two requester counts rotate correctly.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_rr_pick: combinational rotating-priority encoder.
//   i_req   - request vector, one bit per requester
//   i_ptr   - index that currently holds highest priority
//   o_found - at least one request is set
//   o_idx   - first set request scanning i_ptr, i_ptr+1, ... modulo N
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_cand;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from the farthest candidate back to the pointer so the nearest
    // requesting index is the one left standing.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = wrap_add(i_ptr, k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter sharing one uart_tx
// serializer between NUM_REQ byte-stream requesters. An owner keeps the UART
// until its last byte has been serialized or it idles mid-packet for
// GAP_TIMEOUT cycles.
//   clk, rst_n   - clock, synchronous active-low reset
//   req_valid    - per-requester byte valid
//   req_data     - requester i byte on [8i+7:8i]
//   req_last     - byte is the final one of its message
//   req_ready    - byte accepted this cycle (combinational, one-hot or zero)
//   tx_data      - registered byte to uart_tx
//   tx_start     - registered one-cycle start pulse to uart_tx
//   tx_busy      - uart_tx busy
//   grant_valid  - a requester owns the UART
//   grant_id     - current owner
//   abort        - one-cycle pulse when a grant is revoked by gap timeout
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int GAP_TIMEOUT = 1024,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id,
    output logic                      abort
);

    localparam int GAP_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0);

    arb_state_t        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_grant_valid;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_tx_start;
    logic              r_abort;
    logic              r_sent_last;
    logic [GAP_W-1:0]  r_gap;

    logic              w_found;
    logic [ID_W-1:0]   w_pick_id;
    logic              w_owner_valid;
    logic              w_owner_last;
    logic [BYTE_W-1:0] w_owner_data;
    logic [NUM_REQ-1:0] w_ready;

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_id)
    );

    assign w_owner_valid = req_valid[r_grant_id];
    assign w_owner_last  = req_last[r_grant_id];
    assign w_owner_data  = req_data[r_grant_id*BYTE_W +: BYTE_W];

    // Ready waits on tx_busy=0, which also keeps a post-reset issue from
    // colliding with a byte uart_tx is still shifting out.
    always_comb begin
        w_ready = '0;
        if (rst_n && (r_state == ISSUE)) begin
            w_ready[r_grant_id] = ~tx_busy;
        end
    end

    assign req_ready   = w_ready;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign abort       = r_abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ARB;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_abort       <= 1'b0;
            r_sent_last   <= 1'b0;
            r_gap         <= '0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ARB: begin
                    if (w_found) begin
                        r_grant_id    <= w_pick_id;
                        r_grant_valid <= 1'b1;
                        r_gap         <= '0;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_owner_valid && !tx_busy) begin
                        r_tx_data   <= w_owner_data;
                        r_sent_last <= w_owner_last;
                        r_tx_start  <= 1'b1;
                        r_gap       <= '0;
                        r_state     <= START;
                    end else if (!w_owner_valid) begin
                        if ((GAP_TIMEOUT != 0) && (r_gap == GAP_LAST)) begin
                            r_abort       <= 1'b1;
                            r_grant_valid <= 1'b0;
                            r_rr_ptr      <= ID_W'(rr_next(32'(r_grant_id), NUM_REQ));
                            r_state       <= ARB;
                        end else if (r_gap != '1) begin
                            // Saturate rather than wrap when the timeout is disabled.
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end
                START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (r_sent_last) begin
                            r_grant_valid <= 1'b0;
                            r_rr_ptr      <= ID_W'(rr_next(32'(r_grant_id), NUM_REQ));
                            r_state       <= ARB;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int BUSY_CYC = 40;
    localparam int LIMIT    = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  rv [2];
    logic [31:0] rd [2];
    logic [3:0]  rl [2];
    logic [3:0]  rdy4;
    logic [2:0]  rdy3;
    logic [7:0]  txd [2];
    logic        txs [2];
    logic        busy [2] = '{1'b0, 1'b0};
    logic        gv [2];
    logic [1:0]  gid [2];
    logic        ab [2];

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_TIMEOUT(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[0]), .req_data(rd[0]), .req_last(rl[0]), .req_ready(rdy4),
        .tx_data(txd[0]), .tx_start(txs[0]), .tx_busy(busy[0]),
        .grant_valid(gv[0]), .grant_id(gid[0]), .abort(ab[0])
    );

    uart_tx_arbiter #(.NUM_REQ(3), .GAP_TIMEOUT(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[1][2:0]), .req_data(rd[1][23:0]), .req_last(rl[1][2:0]), .req_ready(rdy3),
        .tx_data(txd[1]), .tx_start(txs[1]), .tx_busy(busy[1]),
        .grant_valid(gv[1]), .grant_id(gid[1]), .abort(ab[1])
    );

    // uart_tx stand-in: no reset, busy for BUSY_CYC cycles (10 bits x 4) after a start.
    int ucnt [2] = '{0, 0};
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (busy[d]) begin
                if (ucnt[d] == 1) busy[d] <= 1'b0;
                ucnt[d] <= ucnt[d] - 1;
            end else if (txs[d] === 1'b1) begin
                busy[d] <= 1'b1;
                ucnt[d] <= BUSY_CYC;
            end
        end
    end

    // Observation: log every start, track start width, start-while-busy, aborts.
    int cyc = 0;
    int last_fall = 0;
    int abort_cnt = 0;
    int abort_delta = 0;
    int long_start [2] = '{0, 0};
    int start_busy [2] = '{0, 0};
    logic prev_start [2] = '{1'b0, 1'b0};
    logic prev_busy [2] = '{1'b0, 1'b0};
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (txs[d] === 1'b1) begin
                if (prev_start[d]) long_start[d] <= long_start[d] + 1;
                if (busy[d]) start_busy[d] <= start_busy[d] + 1;
                if (!prev_start[d]) begin
                    if (d == 0) q0.push_back({6'd0, gid[d], txd[d]});
                    else        q1.push_back({6'd0, gid[d], txd[d]});
                end
            end
            prev_start[d] <= (txs[d] === 1'b1);
            prev_busy[d]  <= busy[d];
        end
        if (prev_busy[0] && !busy[0]) last_fall <= cyc;
        if (ab[0] === 1'b1) begin
            abort_cnt   <= abort_cnt + 1;
            abort_delta <= cyc - last_fall;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_bit(input int d, input int id);
        logic [3:0] t;
        t = (d == 0) ? rdy4 : {1'b0, rdy3};
        return t[id[1:0]];
    endfunction

    task automatic send_pkt(input int d, input int id, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input bit mark_last);
        int w;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rv[d][id] = 1'b1;
            rd[d][id*8 +: 8] = (i == 0) ? b0 : (i == 1) ? b1 : b2;
            rl[d][id] = mark_last && (i == n - 1);
            w = 0;
            while (!rdy_bit(d, id) && w < LIMIT) begin
                @(negedge clk);
                w++;
            end
            check("send_ready_wait", 32'(w < LIMIT), 32'd1);
            @(negedge clk);
        end
        rv[d][id] = 1'b0;
        rl[d][id] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input bit chk_busy);
        int w = 0;
        while (gv[d] !== 1'b0 && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        check("grant_drop_wait", 32'(w < LIMIT), 32'd1);
        if (chk_busy) check("grant_drop_after_busy", 32'(busy[d]), 32'd0);
        w = 0;
        while (busy[d] !== 1'b0 && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_log(input int d, input int id, input logic [7:0] data);
        logic [15:0] e;
        e = 16'hFFFF;
        if (d == 0 && q0.size() > 0) e = q0.pop_front();
        else if (d == 1 && q1.size() > 0) e = q1.pop_front();
        check($sformatf("log_d%0d_id%0d_%02h", d, id, data), 32'(e), 32'({6'd0, 2'(id), data}));
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, "_tx_start"},    32'(txs[0]), 32'd0);
        check({tag, "_tx_data"},     32'(txd[0]), 32'd0);
        check({tag, "_grant_valid"}, 32'(gv[0]),  32'd0);
        check({tag, "_grant_id"},    32'(gid[0]), 32'd0);
        check({tag, "_abort"},       32'(ab[0]),  32'd0);
        check({tag, "_req_ready"},   32'(rdy4),   32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rv[d] = '0; rd[d] = '0; rl[d] = '0;
        end
        repeat (3) @(negedge clk);
        rv[0] = 4'hF;
        @(negedge clk);
        check("reset_ready_held_low", 32'(rdy4), 32'd0);
        check("reset_dut3_grant", 32'(gv[1]), 32'd0);
        rv[0] = 4'h0;
        pulse_reset("rst0");

        // Single requester, two-byte packet.
        send_pkt(0, 1, 2, 8'h41, 8'h42, 8'h00, 1'b1);
        wait_idle(0, 1'b1);
        expect_log(0, 1, 8'h41);
        expect_log(0, 1, 8'h42);

        // Pointer now at 2: requesters 0 and 3 together -> 3 wins.
        fork
            send_pkt(0, 0, 1, 8'hA0, 8'h00, 8'h00, 1'b1);
            send_pkt(0, 3, 1, 8'hB3, 8'h00, 8'h00, 1'b1);
        join
        wait_idle(0, 1'b1);
        expect_log(0, 3, 8'hB3);
        expect_log(0, 0, 8'hA0);

        // Simultaneous 3-byte packets from 0 and 2, two rounds.
        pulse_reset("rst1");
        for (int r = 0; r < 2; r++) begin
            fork
                send_pkt(0, 0, 3, 8'h01, 8'h02, 8'h03, 1'b1);
                send_pkt(0, 2, 3, 8'h21, 8'h22, 8'h23, 1'b1);
            join
            wait_idle(0, 1'b1);
        end
        for (int r = 0; r < 2; r++) begin
            expect_log(0, 0, 8'h01); expect_log(0, 0, 8'h02); expect_log(0, 0, 8'h03);
            expect_log(0, 2, 8'h21); expect_log(0, 2, 8'h22); expect_log(0, 2, 8'h23);
        end

        // Gap timeout: req 3 stalls after a non-last byte while req 0 waits.
        fork
            send_pkt(0, 3, 1, 8'h10, 8'h00, 8'h00, 1'b0);
            begin
                int w = 0;
                while (!(gv[0] === 1'b1 && gid[0] === 2'd3) && w < LIMIT) begin
                    @(negedge clk);
                    w++;
                end
                check("gap_grant3_wait", 32'(w < LIMIT), 32'd1);
                send_pkt(0, 0, 2, 8'h55, 8'h56, 8'h00, 1'b1);
            end
        join
        wait_idle(0, 1'b1);
        check("gap_abort_count", 32'(abort_cnt), 32'd1);
        check("gap_abort_timing", 32'(abort_delta), 32'd17);
        expect_log(0, 3, 8'h10);
        expect_log(0, 0, 8'h55);
        expect_log(0, 0, 8'h56);

        // Reset mid-byte: outputs clear, next start waits for tx_busy=0.
        send_pkt(0, 1, 1, 8'h77, 8'h00, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        check("midbyte_busy_seen", 32'(busy[0]), 32'd1);
        pulse_reset("rst_mid");
        check("midbyte_busy_after_reset", 32'(busy[0]), 32'd1);
        send_pkt(0, 2, 1, 8'h99, 8'h00, 8'h00, 1'b1);
        wait_idle(0, 1'b1);
        expect_log(0, 1, 8'h77);
        expect_log(0, 2, 8'h99);

        // NUM_REQ=3: pointer wraps 2 -> 0; a sole requester is re-granted.
        send_pkt(1, 1, 1, 8'h31, 8'h00, 8'h00, 1'b1);
        wait_idle(1, 1'b1);
        send_pkt(1, 2, 2, 8'h32, 8'h33, 8'h00, 1'b1);
        wait_idle(1, 1'b1);
        send_pkt(1, 2, 1, 8'h34, 8'h00, 8'h00, 1'b1);
        wait_idle(1, 1'b1);
        fork
            send_pkt(1, 0, 1, 8'h40, 8'h00, 8'h00, 1'b1);
            send_pkt(1, 2, 1, 8'h42, 8'h00, 8'h00, 1'b1);
        join
        wait_idle(1, 1'b1);
        expect_log(1, 1, 8'h31);
        expect_log(1, 2, 8'h32);
        expect_log(1, 2, 8'h33);
        expect_log(1, 2, 8'h34);
        expect_log(1, 0, 8'h40);
        expect_log(1, 2, 8'h42);

        check("start_width_dut4", 32'(long_start[0]), 32'd0);
        check("start_width_dut3", 32'(long_start[1]), 32'd0);
        check("start_while_busy_dut4", 32'(start_busy[0]), 32'd0);
        check("start_while_busy_dut3", 32'(start_busy[1]), 32'd0);
        check("abort_total", 32'(abort_cnt), 32'd1);
        check("log_empty_dut4", 32'(q0.size()), 32'd0);
        check("log_empty_dut3", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte-stream requesters (debug console, CPU trace, error reporter, ...).
- Each requester offers bytes on a valid/ready interface and marks the final byte of a message with last.
- Once granted, a requester owns the UART until its last byte is sent or a gap timeout expires, so messages never interleave.
- Drives uart_tx's data/start inputs and sequences on its busy output.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_TIMEOUT, 1024, cycles an owner may hold valid low mid-packet before the grant is revoked; 0 disables the timeout
ID_W, $clog2(NUM_REQ), width of grant_id (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*8  requester i byte on bits [8i+7:8i]
req_last  in  NUM_REQ  byte is last of message (qualified by valid)
req_ready  out  NUM_REQ  byte accepted this cycle (combinational, one-hot or zero)
tx_data  out  8  byte to uart_tx (registered)
tx_start  out  1  one-cycle start pulse to uart_tx (registered)
tx_busy  in  1  uart_tx busy
grant_valid  out  1  a requester currently owns the UART
grant_id  out  ID_W  current owner index
abort  out  1  one-cycle pulse when a grant is revoked by gap timeout

Behaviour:
- Reset, sampled on posedge clk with rst_n=0:
  - state=ARB, rr_ptr=0, tx_start=0, tx_data=0, grant_valid=0, grant_id=0, abort=0, gap counter=0, sent_last=0.
  - req_ready=0 while rst_n=0.
  - Reset mid-byte abandons the packet. uart_tx has no reset, so the controller must not issue again until it sees tx_busy=0.
- States: ARB, ISSUE, START, WAIT_BUSY, WAIT_DONE.
- ARB:
  - Pick the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If found: grant_id<=i, grant_valid<=1, gap counter<=0, go to ISSUE. Otherwise stay in ARB.
- ISSUE:
  - req_ready[grant_id] = (tx_busy==0). All other ready bits are 0.
  - Transfer when valid and ready are both high: tx_data<=byte, sent_last<=req_last[grant_id], tx_start<=1, go to START.
  - If the owner's valid is low, the gap counter increments. When GAP_TIMEOUT!=0 and the counter reaches GAP_TIMEOUT-1: abort<=1 for one cycle, grant_valid<=0, rr_ptr<=grant_id+1 (mod NUM_REQ), go to ARB.
  - Gap counter clears on every transfer.
- START: tx_start<=0 (pulse is exactly 1 cycle). Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for tx_busy=1, which uart_tx raises one cycle after sampling start.
  - No timeout here; uart_tx always responds.
- WAIT_DONE: on tx_busy=0:
  - If sent_last: grant_valid<=0, rr_ptr<=grant_id+1 (mod NUM_REQ), go to ARB.
  - Else go to ISSUE (same owner).
- Latencies:
  - Idle to first tx_start: 3 cycles (ARB, ISSUE transfer, START register).
  - Back-to-back bytes within a packet: next transfer 1 cycle after tx_busy falls.
- Simultaneous requests are resolved purely by rr_ptr; a requester that just finished has lowest priority next round.
- A requester raising valid while not owner simply waits. Its ready stays 0 and its data must be held stable (valid must not drop without a transfer, except at the owner gap timeout).
- req_last on a non-owner or with valid=0 is ignored.
- Counter widths: gap counter $clog2(GAP_TIMEOUT+1) bits, saturating (no wrap). rr_ptr wraps NUM_REQ-1 to 0 for non-power-of-2 NUM_REQ.

Decomposition:
- Package uart_arb_pkg holds:
  - the state enum (ARB, ISSUE, START, WAIT_BUSY, WAIT_DONE);
  - a function rr_next(ptr, n) for modulo increment;
  - constant BYTE_W=8.
- One sub-module, uart_rr_pick: combinational rotating-priority encoder (req vector, rr_ptr, returning found and index). It is reusable by other shared-peripheral arbiters.
- The FSM, gap counter and output registers stay in the top.

Test Plan:
- Bench setup: real uart_tx with DELAY_FRAMES=4, GAP_TIMEOUT=16.
- Single requester: req 1 sends {0x41, 0x42 last} -> two tx_start pulses, tx_data 0x41 then 0x42; grant_id=1 throughout; grant_valid drops after the second tx_busy fall; rr_ptr=2.
- Simultaneous: req 0 and req 2 valid at the same cycle after reset, each sending 3-byte packets -> line carries all of req 0 then all of req 2, never interleaved. Repeat with both re-requesting -> order 0,2,0,2 (round-robin).
- Gap timeout: req 3 sends 0x10 (not last), then holds valid low for 20 cycles -> abort pulses exactly once, 16 cycles after entering ISSUE; pending req 0 is granted next.
- Start/busy timing: check tx_start is high exactly 1 cycle per byte and no second start occurs while tx_busy=1. Reset: assert rst_n=0 mid-byte for 1 cycle -> all outputs reach reset values; the next tx_start does not occur before tx_busy=0.
- Boundary: NUM_REQ=3, only req 2 active with rr_ptr=2 -> after the packet rr_ptr wraps to 0. Req 2 re-requests alone -> it is granted again (no starvation of a sole requester).
